window_feeder: RTL and testbench
================================

WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 SIZE, 8, pixel width in bits.
REQ-002 IMG_W, 16, image width in pixels (>=3).
REQ-003 IMG_H, 16, image height in lines (>=3).
REQ-004 GAP, 37, DSO-low cycles between two windows (>=1), matches downstream median compute time.
REQ-005 CLK  input  1  single clock; all state SHALL update on rising edge.
REQ-006 nRST  input  1  reset, asynchronous, active-low.
REQ-007 PI  input  SIZE  raster-order input pixel.
REQ-008 PVALID  input  1  PI valid.
REQ-009 SOF  input  1  qualifies PI as first pixel of frame (row 0, col 0).
REQ-010 PREADY  output  1  feeder accepts PI this cycle.
REQ-011 DO  output  SIZE  serialized window pixel to median stage.
REQ-012 DSO  output  1  high while DO carries one of the 9 window pixels.

Function
REQ-013 Pixel SHALL be accepted on a rising edge with PVALID=1 and PREADY=1; otherwise no state other than FSM/gap counters SHALL change.
REQ-014 FSM states SHALL be ACCEPT, SEND, WAIT; PREADY=1 only in ACCEPT (decoded from state register).
REQ-015 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL give the position of the accepted pixel; after acceptance col increments, wraps to 0 at IMG_W-1 with row increment; row wraps to 0 after IMG_H-1.
REQ-016 Accepted pixel with SOF=1 SHALL be treated as row 0, col 0 regardless of counters (resync); counters then continue from col 1.
REQ-017 Two line buffers of IMG_W pixels SHALL hold the previous two lines; 3x3 window SHALL shift left by one column on each acceptance, new column = {line row-2, line row-1, PI} at that column.
REQ-018 Window SHALL be valid for an accepted pixel at row>=2 and col>=2; edge pixels produce no window.
REQ-019 ACCEPT -> SEND on acceptance of a window-valid pixel; otherwise stay ACCEPT (throughput 1 pixel/cycle).
REQ-020 In SEND, DSO=1 for exactly 9 consecutive cycles starting the cycle after acceptance; DO order top-left, top-mid, top-right, mid-left, ..., bottom-right (row-major, center 5th).
REQ-021 SEND -> WAIT after 9th pixel; WAIT holds DSO=0, PREADY=0 for exactly GAP cycles, then -> ACCEPT.
REQ-022 DO and DSO SHALL be registered; DO SHALL hold last value when DSO=0.
REQ-023 PVALID and SOF SHALL be ignored outside ACCEPT.
REQ-024 Counter widths SHALL be $clog2 of their range; no overflow beyond stated wraps.

Reset
REQ-025 nRST=0 SHALL asynchronously set state=ACCEPT, col=0, row=0, serialize and gap counters=0, DO=0, DSO=0; PREADY=1 during and after reset.
REQ-026 Line buffer and window contents SHALL NOT require reset; reset mid-SEND/WAIT SHALL abort the window with DSO=0 immediately.

Structure
REQ-027 Package median_pkg SHALL hold state enum (ACCEPT, SEND, WAIT) and default SIZE/IMG_W/IMG_H/GAP constants.
REQ-028 One sub-module line_buffer (IMG_W-deep, SIZE-wide, shift-enable, tap output) SHALL be instantiated twice.

Verification
REQ-029 IMG_W=IMG_H=4, GAP=3, pixels 0..15, SOF on 0, PVALID=1 -> first DSO burst after pixel 10: 0,1,2,4,5,6,8,9,10; then 1,2,3,5,6,7,9,10,11; 4,5,6,8,9,10,12,13,14; 5,6,7,9,10,11,13,14,15; exactly 4 bursts.
REQ-030 Same stimulus -> PREADY=0 for exactly 9+3=12 cycles after each window-valid acceptance, 1 otherwise.
REQ-031 PVALID toggled 1/0 each cycle -> identical DO sequence as REQ-029, only timing shifted.
REQ-032 SOF asserted on 6th pixel of a frame -> counters resync; no window until 2 further lines + 3 pixels accepted.
REQ-033 nRST pulsed during 4th SEND cycle -> DSO=0, DO=0 same edge; PREADY=1; next frame with SOF reproduces REQ-029.
REQ-034 Two back-to-back 4x4 frames without SOF on the second -> 8 windows, second set values offset by 16.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and default geometry for the 3x3 window feeder.
package median_pkg;

    localparam int unsigned SIZE_DEF  = 8;
    localparam int unsigned IMG_W_DEF = 16;
    localparam int unsigned IMG_H_DEF = 16;
    localparam int unsigned GAP_DEF   = 37;
    localparam int unsigned WIN_N     = 9;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: shifts on en, tap is the pixel shifted in DEPTH shifts ago.
module line_buffer #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk,
    input  logic            en,
    input  logic [SIZE-1:0] din,
    output logic [SIZE-1:0] tap
);

    logic [SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/window_feeder.sv
// Builds a 3x3 window from a raster pixel stream and serializes it, with a
// fixed idle gap after each window for the downstream median stage.
module window_feeder
    import median_pkg::*;
#(
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned GAP   = GAP_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [SIZE-1:0] PI,
    input  logic            PVALID,
    input  logic            SOF,
    output logic            PREADY,
    output logic [SIZE-1:0] DO,
    output logic            DSO
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned SER_W = $clog2(WIN_N);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col_eff;
    logic [ROW_W-1:0]  row_eff;
    logic [SER_W-1:0]  ser;
    logic [SER_W-1:0]  ser_nxt;
    logic [GAP_W-1:0]  gap;
    logic              accept;
    logic              win_ok;
    logic [SIZE-1:0]   tap_mid;
    logic [SIZE-1:0]   tap_top;
    logic [SIZE-1:0]   win [WIN_N];

    assign PREADY  = (state == ACCEPT);
    assign accept  = PVALID && (state == ACCEPT);
    assign col_eff = SOF ? '0 : col;
    assign row_eff = SOF ? '0 : row;
    assign win_ok  = (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
    assign ser_nxt = ser + SER_W'(1);

    // Row-1 line feeds row-2 line so both stay column-aligned with PI.
    line_buffer #(.SIZE(SIZE), .DEPTH(IMG_W)) u_lb_mid (
        .clk (CLK),
        .en  (accept),
        .din (PI),
        .tap (tap_mid)
    );

    line_buffer #(.SIZE(SIZE), .DEPTH(IMG_W)) u_lb_top (
        .clk (CLK),
        .en  (accept),
        .din (tap_mid),
        .tap (tap_top)
    );

    // Window stored row-major; each acceptance shifts in the column {top, mid, PI}.
    always_ff @(posedge CLK) begin
        if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= tap_top;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= tap_mid;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= PI;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_eff == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (row_eff == ROW_W'(IMG_H - 1)) ? '0 : row_eff + ROW_W'(1);
            end else begin
                col <= col_eff + COL_W'(1);
                row <= row_eff;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT: if (accept && win_ok)                  state_nxt = SEND;
            SEND:   if (ser == SER_W'(WIN_N - 1))          state_nxt = WAIT;
            WAIT:   if (gap == GAP_W'(GAP - 1))            state_nxt = ACCEPT;
            default:                                       state_nxt = ACCEPT;
        endcase
    end

    // ser indexes the pixel currently on DO; the first pixel is taken from the
    // pre-shift window (win[1] becomes the top-left after this edge's shift).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            DO  <= '0;
            DSO <= 1'b0;
            ser <= '0;
            gap <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (accept && win_ok) begin
                        DO  <= win[1];
                        DSO <= 1'b1;
                        ser <= '0;
                    end
                end
                SEND: begin
                    if (ser == SER_W'(WIN_N - 1)) begin
                        DSO <= 1'b0;
                        ser <= '0;
                        gap <= '0;
                    end else begin
                        DO  <= win[ser_nxt];
                        ser <= ser_nxt;
                    end
                end
                WAIT: begin
                    gap <= (gap == GAP_W'(GAP - 1)) ? '0 : gap + GAP_W'(1);
                end
                default: begin
                    DSO <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder on a 4x4 image with a 3-cycle gap,
// checked against a 2-D image model and a queue of expected window pixels.
module tb_window_feeder;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;
    localparam int unsigned G = 3;
    localparam int BUSY_LEN = 9 + G;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] pi = '0;
    logic       pvalid = 1'b0;
    logic       sof = 1'b0;
    logic       pready;
    logic [7:0] dout;
    logic       dso;

    window_feeder #(.SIZE(8), .IMG_W(W), .IMG_H(H), .GAP(G)) dut (
        .CLK    (clk),
        .nRST   (nrst),
        .PI     (pi),
        .PVALID (pvalid),
        .SOF    (sof),
        .PREADY (pready),
        .DO     (dout),
        .DSO    (dso)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         busy = 0;
    int         mrow = 0;
    int         mcol = 0;
    int         img [H][W];
    logic [7:0] exp_q [$];
    logic [7:0] dlog [$];
    logic [7:0] last_do = '0;
    logic       prev_dso = 1'b0;
    int         bursts = 0;
    logic       tog = 1'b1;
    int         ref_seq [36];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        fail_cnt++;
        $display("FAIL %s: observed none expected event", tag);
    endtask

    // Reference model of one accepted pixel, indexed by image position.
    task automatic model_accept(input logic [7:0] px, input logic s);
        int r, c;
        r = s ? 0 : mrow;
        c = s ? 0 : mcol;
        img[r][c] = int'(px);
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp_q.push_back(8'(img[r-2+i][c-2+j]));
            busy = BUSY_LEN;
        end
        if (c == int'(W) - 1) begin
            mcol = 0;
            mrow = (r == int'(H) - 1) ? 0 : r + 1;
        end else begin
            mcol = c + 1;
            mrow = r;
        end
    endtask

    // One clock: check outputs at the falling edge, drive, then update the model.
    task automatic cycle(input logic [7:0] px, input logic s, input logic pv, output logic acc);
        logic exp_ready, exp_dso;
        logic [7:0] e;
        exp_ready = (busy == 0);
        exp_dso   = (busy > int'(G));
        check("pready", 32'(pready), 32'(exp_ready));
        check("dso", 32'(dso), 32'(exp_dso));
        if (dso) dlog.push_back(dout);
        if (dso && !prev_dso) bursts++;
        prev_dso = dso;
        if (exp_dso) begin
            if (exp_q.size() == 0) begin
                fail_now("do_underflow");
            end else begin
                e = exp_q.pop_front();
                check("do", 32'(dout), 32'(e));
                last_do = e;
            end
        end else begin
            check("do_hold", 32'(dout), 32'(last_do));
        end
        pi = px;
        sof = s;
        pvalid = pv;
        @(posedge clk);
        acc = exp_ready && pv;
        if (busy > 0) busy--;
        if (acc) model_accept(px, s);
        @(negedge clk);
        pvalid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic send(input logic [7:0] px, input logic s, input logic toggle);
        logic acc;
        for (int t = 0; t < 50; t++) begin
            logic pv;
            pv = toggle ? tog : 1'b1;
            tog = ~tog;
            cycle(px, s, pv, acc);
            if (acc) return;
        end
        fail_now("accept_timeout");
    endtask

    task automatic drain();
        logic acc;
        for (int t = 0; t < 50; t++) begin
            if (busy == 0) return;
            cycle(8'd0, 1'b0, 1'b0, acc);
        end
        fail_now("drain_timeout");
    endtask

    task automatic send_frame(input int base, input logic toggle);
        for (int p = 0; p < int'(W * H); p++)
            send(8'(base + p), (p == 0), toggle);
    endtask

    // Compare captured DO bursts with the reference 4x4 sequence, offset per frame.
    task automatic check_log(input string tag, input int nwin);
        check({tag, "_bursts"}, 32'(bursts), 32'(nwin));
        check({tag, "_len"}, 32'(dlog.size()), 32'(nwin * 9));
        for (int i = 0; i < nwin * 9 && i < dlog.size(); i++)
            check({tag, "_seq"}, 32'(dlog[i]), 32'(ref_seq[i % 36] + 16 * (i / 36)));
        dlog.delete();
        bursts = 0;
    endtask

    initial begin
        logic acc;
        ref_seq = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                    1, 2, 3, 5, 6, 7, 9, 10, 11,
                    4, 5, 6, 8, 9, 10, 12, 13, 14,
                    5, 6, 7, 9, 10, 11, 13, 14, 15};

        @(negedge clk);
        check("rst_pready", 32'(pready), 32'd1);
        check("rst_dso", 32'(dso), 32'd0);
        check("rst_do", 32'(dout), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Continuous stream: 4 windows with a 12-cycle ready drop each.
        send_frame(0, 1'b0);
        drain();
        check_log("stream", 4);

        // Valid toggling every cycle: same data, different timing.
        send_frame(0, 1'b1);
        drain();
        check_log("toggle", 4);

        // Two frames back to back, SOF only on the first.
        for (int p = 0; p < 32; p++)
            send(8'(p), (p == 0), 1'b0);
        drain();
        check_log("two_frames", 8);

        // SOF on the 6th pixel resynchronizes the counters.
        for (int p = 0; p < 21; p++)
            send(8'(100 + p), (p == 5), 1'b0);
        drain();
        check("resync_bursts", 32'(bursts), 32'd4);
        check("resync_queue", 32'(exp_q.size()), 32'd0);
        dlog.delete();
        bursts = 0;

        // Reset during the 4th DSO cycle of a window.
        for (int p = 0; p < 11; p++)
            send(8'(p), (p == 0), 1'b0);
        for (int t = 0; t < 10 && busy > BUSY_LEN - 3; t++)
            cycle(8'd0, 1'b0, 1'b0, acc);
        check("pre_rst_dso", 32'(dso), 32'd1);
        nrst = 1'b0;
        #1;
        check("mid_rst_dso", 32'(dso), 32'd0);
        check("mid_rst_do", 32'(dout), 32'd0);
        check("mid_rst_pready", 32'(pready), 32'd1);
        busy = 0;
        exp_q.delete();
        dlog.delete();
        last_do = '0;
        mrow = 0;
        mcol = 0;
        prev_dso = 1'b0;
        bursts = 0;
        @(negedge clk);
        nrst = 1'b1;
        send_frame(0, 1'b0);
        drain();
        check_log("after_rst", 4);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
